uart_byte_rx: RTL and testbench

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_byte_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_byte_rx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8N1 framing, 2-flop synchronized input, mid-bit sampling.
// Emits a one-cycle rx_done for good frames and frame_err for a low stop bit.
module uart_byte_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_state,
  output logic       frame_err
);

  localparam int          BPS_INT = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BPS_M1  = 16'(BPS_INT - 1);
  localparam logic [15:0] HALF    = 16'(BPS_INT >> 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        sync1;
  logic        rx_s;
  logic        rx_d;
  logic        start_det;
  logic [15:0] cnt;
  logic [15:0] cnt_next;
  logic [2:0]  idx;
  logic [2:0]  idx_next;
  logic [7:0]  shreg;
  logic [7:0]  shreg_next;
  logic [7:0]  data_next;
  logic        done_next;
  logic        err_next;
  logic        at_half;
  logic        at_end;

  // Input synchronizer and edge-detect delay; reset to idle-high to avoid a false start
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= rs232_rx;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  assign start_det = rx_d & ~rx_s;
  assign at_half   = (cnt == HALF);
  assign at_end    = (cnt == BPS_M1);

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_next = state;
    idx_next   = idx;
    shreg_next = shreg;
    data_next  = rx_data;
    done_next  = 1'b0;
    err_next   = 1'b0;
    cnt_next   = 16'd0;
    case (state)
      IDLE: begin
        idx_next = 3'd0;
        if (start_det) begin
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (at_half && rx_s) begin
          state_next = IDLE;
        end else if (at_end) begin
          state_next = DATA;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (at_half) begin
          shreg_next = {rx_s, shreg[7:1]};
        end else begin
          shreg_next = shreg;
        end
        if (at_end) begin
          if (idx == 3'd7) begin
            state_next = STOP;
            idx_next   = 3'd0;
          end else begin
            state_next = DATA;
            idx_next   = idx + 3'd1;
          end
        end else begin
          state_next = DATA;
          idx_next   = idx;
        end
      end
      STOP: begin
        // Leave at mid-stop so the next start edge is never missed
        if (at_half) begin
          state_next = IDLE;
          if (rx_s) begin
            data_next = shreg;
            done_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          state_next = STOP;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 3'd0;
      end
    endcase

    if ((state == IDLE) || (state_next == IDLE)) begin
      cnt_next = 16'd0;
    end else if (at_end) begin
      cnt_next = 16'd0;
    end else begin
      cnt_next = cnt + 16'd1;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt       <= 16'd0;
      idx       <= 3'd0;
      shreg     <= 8'd0;
      rx_data   <= 8'd0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_state  <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      idx       <= idx_next;
      shreg     <= shreg_next;
      rx_data   <= data_next;
      rx_done   <= done_next;
      frame_err <= err_next;
      rx_state  <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed self-checking bench for uart_byte_rx with BPS=16, HALF=8.
module tb_uart_byte_rx;

  localparam int BPS = 16;

  logic       clk_in;
  logic       rst_in;
  logic       rs232_rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_state;
  logic       frame_err;

  int checks;
  int errors;
  int n_done;
  int n_ferr;
  int n_both;
  int n_hi;
  logic [7:0] got_q[$];

  uart_byte_rx #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rs232_rx  (rs232_rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_state  (rx_state),
    .frame_err (frame_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Output monitor, sampled away from the active edge
  always @(negedge clk_in) begin
    if (rx_done) begin
      n_done = n_done + 1;
      got_q.push_back(rx_data);
    end
    if (frame_err) n_ferr = n_ferr + 1;
    if (rx_done && frame_err) n_both = n_both + 1;
    if (rx_state) n_hi = n_hi + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_done = 0;
    n_ferr = 0;
    n_hi   = 0;
    got_q.delete();
  endtask

  task automatic drive_bit(input logic b);
    rs232_rx = b;
    repeat (BPS) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    n_both   = 0;
    clear_mon();
    rst_in   = 1'b1;
    rs232_rx = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check_eq("rst_data", {24'd0, rx_data}, 32'h00);
    check_eq("rst_done", {31'd0, rx_done}, 32'd0);
    check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("rst_state", {31'd0, rx_state}, 32'd0);
    @(posedge clk_in);
    #1;

    // Single good frame
    clear_mon();
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1);
    check_eq("a5_done", n_done, 32'd1);
    check_eq("a5_ferr", n_ferr, 32'd0);
    check_eq("a5_byte", {24'd0, got_q[0]}, 32'hA5);
    check_eq("a5_rxdata", {24'd0, rx_data}, 32'hA5);

    // 4-clock low glitch: false start rejected at mid-bit sample
    clear_mon();
    rs232_rx = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    rs232_rx = 1'b1;
    repeat (40) @(posedge clk_in);
    #1;
    check_eq("glitch_seen", {31'd0, (n_hi > 0)}, 32'd1);
    check_eq("glitch_len", {31'd0, (n_hi <= 9)}, 32'd1);
    check_eq("glitch_done", n_done, 32'd0);
    check_eq("glitch_ferr", n_ferr, 32'd0);

    // Bad stop bit
    clear_mon();
    send_frame(8'h55, 1'b0);
    drive_bit(1'b1);
    check_eq("stop0_ferr", n_ferr, 32'd1);
    check_eq("stop0_done", n_done, 32'd0);
    check_eq("stop0_keep", {24'd0, rx_data}, 32'hA5);

    // Back-to-back frames, no idle gap
    clear_mon();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    drive_bit(1'b1);
    check_eq("b2b_count", n_done, 32'd3);
    check_eq("b2b_0", {24'd0, got_q[0]}, 32'h00);
    check_eq("b2b_1", {24'd0, got_q[1]}, 32'hFF);
    check_eq("b2b_2", {24'd0, got_q[2]}, 32'h3C);
    check_eq("b2b_ferr", n_ferr, 32'd0);

    // Reset pulse mid-frame (data bit 4 of 0x81), sender aborts to idle
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1 & (i == 0));
    rs232_rx = 1'b0;
    repeat (8) @(posedge clk_in);
    #1;
    rst_in   = 1'b1;
    rs232_rx = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check_eq("mid_rst_state", {31'd0, rx_state}, 32'd0);
    check_eq("mid_rst_data", {24'd0, rx_data}, 32'h00);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check_eq("mid_rst_idle", {31'd0, rx_state}, 32'd0);
    send_frame(8'h42, 1'b1);
    drive_bit(1'b1);
    check_eq("rst_then_done", n_done, 32'd1);
    check_eq("rst_then_byte", {24'd0, got_q[0]}, 32'h42);
    check_eq("rst_then_ferr", n_ferr, 32'd0);

    // Break: 30 bit-times low, 2 high, then a good frame
    clear_mon();
    rs232_rx = 1'b0;
    repeat (30 * BPS) @(posedge clk_in);
    #1;
    check_eq("break_ferr_early", n_ferr, 32'd1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h7E, 1'b1);
    drive_bit(1'b1);
    check_eq("break_ferr", n_ferr, 32'd1);
    check_eq("break_done", n_done, 32'd1);
    check_eq("break_byte", {24'd0, got_q[0]}, 32'h7E);

    check_eq("never_both", n_both, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
